// File: rtl/perf_mon_ctrl.sv
// ============================================================================
//  Module      : perf_mon_ctrl
//  Description : L1 cache performance monitor. Four 64-bit event counters
//                (L1I accesses/misses, L1D accesses/misses) governed by a
//                STOP/RUN/CLEAR state machine, with sticky overflow flags and
//                a simple req/ack register port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                     : clock, all state changes on rising edge
//    rst                     : asynchronous active-high reset
//    ic_en, ic_hit, ic_vbit  : L1I access strobe, hit, valid lookup
//    dc_en, dc_hit, dc_vbit  : L1D access strobe, hit, valid lookup
//    req, we, addr, wdata    : register request (held until ack)
//    ack                     : one-cycle completion, one cycle after accept
//    rdata                   : read data, valid while ack=1, zero otherwise
//    irq                     : overflow interrupt
//  Register map (addr)
//    0 CTRL  wr: bit2 clear > bit0 start > bit1 stop; rd: {clear, run}
//    1 OVF   sticky flags {DCM, DCA, ICM, ICA}, write-1-to-clear
//    2/3 ICA lo/hi, 4/5 ICM, 6/7 DCA, 8/9 DCM (hi reads return shadow)
//    10..15 read as zero; writes to 2..15 are ignored
//  Configuration
//    PERF_OVF_IRQ_EN : when defined, irq is a registered OR of the overflow
//                      flags; when undefined, irq is tied low.
// ============================================================================
`default_nettype none

module perf_mon_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_en,
    input  logic        ic_hit,
    input  logic        ic_vbit,
    input  logic        dc_en,
    input  logic        dc_hit,
    input  logic        dc_vbit,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [3:0] c_addr_ctrl   = 4'd0;
    localparam logic [3:0] c_addr_ovf    = 4'd1;
    localparam logic [3:0] c_addr_ica_lo = 4'd2;
    localparam logic [3:0] c_addr_ica_hi = 4'd3;
    localparam logic [3:0] c_addr_icm_lo = 4'd4;
    localparam logic [3:0] c_addr_icm_hi = 4'd5;
    localparam logic [3:0] c_addr_dca_lo = 4'd6;
    localparam logic [3:0] c_addr_dca_hi = 4'd7;
    localparam logic [3:0] c_addr_dcm_lo = 4'd8;
    localparam logic [3:0] c_addr_dcm_hi = 4'd9;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [63:0] r_ica;
    logic [63:0] r_icm;
    logic [63:0] r_dca;
    logic [63:0] r_dcm;
    logic [3:0]  r_ovf;
    logic [31:0] r_shadow;
    logic        r_ack;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_ovf_wr;
    logic        w_run;
    logic        w_clear;
    logic [3:0]  w_evt;
    logic [3:0]  w_wrap;
    logic [3:0]  w_ovf_clr;
    logic [31:0] w_rd_data;
    logic [31:0] w_shadow_cap;
    logic        w_lo_rd;
    logic        w_unused_wdata;

    // ------------------------------------------------------------------------
    // Request handshake: a cycle with ack high is the tail of the previous
    // request, so a still-asserted req there is not a new request.
    // ------------------------------------------------------------------------
    assign w_accept  = req & ~r_ack;
    assign w_wr      = w_accept & we;
    assign w_rd      = w_accept & ~we;
    assign w_ctrl_wr = w_wr & (addr == c_addr_ctrl);
    assign w_ovf_wr  = w_wr & (addr == c_addr_ovf);
    assign w_ovf_clr = w_ovf_wr ? wdata[3:0] : 4'b0000;

    // Only the low control/flag bits of wdata carry meaning.
    assign w_unused_wdata = &{1'b0, wdata[31:4]};

    assign w_run   = (r_state == ST_RUN);
    assign w_clear = (r_state == ST_CLEAR);

    // Event qualification; counting uses the state before any CTRL write
    // landing on the same edge.
    assign w_evt[0] = w_run & ic_en;
    assign w_evt[1] = w_run & ic_vbit & ~ic_hit;
    assign w_evt[2] = w_run & dc_en;
    assign w_evt[3] = w_run & dc_vbit & ~dc_hit;

    assign w_wrap[0] = w_evt[0] & (&r_ica);
    assign w_wrap[1] = w_evt[1] & (&r_icm);
    assign w_wrap[2] = w_evt[2] & (&r_dca);
    assign w_wrap[3] = w_evt[3] & (&r_dcm);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_STOP, ST_RUN: begin
                if (w_ctrl_wr) begin
                    if (wdata[2]) begin
                        w_state_next = ST_CLEAR;
                    end else if (wdata[0]) begin
                        w_state_next = ST_RUN;
                    end else if (wdata[1]) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            // CLEAR is a single-cycle pulse; no request can be accepted in
            // it because ack is high for the write that caused it.
            ST_CLEAR: w_state_next = ST_STOP;
            default:  w_state_next = ST_STOP;
        endcase
    end

    // ------------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ica <= 64'd0;
            r_icm <= 64'd0;
            r_dca <= 64'd0;
            r_dcm <= 64'd0;
        end else if (w_clear) begin
            r_ica <= 64'd0;
            r_icm <= 64'd0;
            r_dca <= 64'd0;
            r_dcm <= 64'd0;
        end else begin
            if (w_evt[0]) r_ica <= r_ica + 64'd1;
            if (w_evt[1]) r_icm <= r_icm + 64'd1;
            if (w_evt[2]) r_dca <= r_dca + 64'd1;
            if (w_evt[3]) r_dcm <= r_dcm + 64'd1;
        end
    end

    // Sticky overflow flags: a wrap in the same cycle as a W1C wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 4'b0000;
        end else if (w_clear) begin
            r_ovf <= 4'b0000;
        end else begin
            r_ovf <= (r_ovf & ~w_ovf_clr) | w_wrap;
        end
    end

    // ------------------------------------------------------------------------
    // Read mux. A lo-word read also yields that counter's upper half, which
    // is latched into the shadow so the following hi-word read is coherent.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_data    = 32'd0;
        w_shadow_cap = 32'd0;
        w_lo_rd      = 1'b0;
        case (addr)
            c_addr_ctrl:   w_rd_data = {30'd0, w_clear, w_run};
            c_addr_ovf:    w_rd_data = {28'd0, r_ovf};
            c_addr_ica_lo: begin
                w_rd_data    = r_ica[31:0];
                w_shadow_cap = r_ica[63:32];
                w_lo_rd      = 1'b1;
            end
            c_addr_icm_lo: begin
                w_rd_data    = r_icm[31:0];
                w_shadow_cap = r_icm[63:32];
                w_lo_rd      = 1'b1;
            end
            c_addr_dca_lo: begin
                w_rd_data    = r_dca[31:0];
                w_shadow_cap = r_dca[63:32];
                w_lo_rd      = 1'b1;
            end
            c_addr_dcm_lo: begin
                w_rd_data    = r_dcm[31:0];
                w_shadow_cap = r_dcm[63:32];
                w_lo_rd      = 1'b1;
            end
            c_addr_ica_hi, c_addr_icm_hi,
            c_addr_dca_hi, c_addr_dcm_hi: w_rd_data = r_shadow;
            default:       w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= 32'd0;
        end else if (w_clear) begin
            r_shadow <= 32'd0;
        end else if (w_rd && w_lo_rd) begin
            r_shadow <= w_shadow_cap;
        end
    end

    // Response: data is sampled on the accept edge and presented with ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= w_accept;
            r_rdata <= w_rd ? w_rd_data : 32'd0;
        end
    end

    assign ack   = r_ack;
    assign rdata = r_rdata;

    // ------------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------------
`ifdef PERF_OVF_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_ovf;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_perf_mon_ctrl.sv
// ============================================================================
//  Module      : tb_perf_mon_ctrl
//  Description : Directed self-checking bench for perf_mon_ctrl. Read
//                expectations are queued when a request is driven and
//                compared when ack arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_perf_mon_ctrl;

`ifdef PERF_OVF_IRQ_EN
    localparam logic c_irq_en = 1'b1;
`else
    localparam logic c_irq_en = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ic_en = 1'b0, ic_hit = 1'b0, ic_vbit = 1'b0;
    logic        dc_en = 1'b0, dc_hit = 1'b0, dc_vbit = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        ack;
    logic [31:0] rdata;
    logic        irq;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q_exp[$];
    string       q_tag[$];

    perf_mon_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ic_en   (ic_en),
        .ic_hit  (ic_hit),
        .ic_vbit (ic_vbit),
        .dc_en   (dc_en),
        .dc_hit  (dc_hit),
        .dc_vbit (dc_vbit),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Waits a bounded number of cycles for ack; a timeout is a failed check.
    task automatic wait_ack(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $error("FAIL %s: observed=no ack expected=ack within 4 cycles", tag);
        end
    endtask

    // Called at a negedge; returns at a negedge with ack already low.
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input string tag);
        bit ok;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        wait_ack(tag, ok);
        @(negedge clk);
        req = 1'b0; we = 1'b0; wdata = 32'd0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        bit          ok;
        logic [31:0] e;
        string       t;
        q_exp.push_back(exp);
        q_tag.push_back(tag);
        req = 1'b1; we = 1'b0; addr = a;
        wait_ack(tag, ok);
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        if (ok) check(t, {32'd0, rdata}, {32'd0, e});
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        @(negedge clk);
        bus_read(4'd0, 32'h0, "ctrl_after_rst");
        bus_read(4'd1, 32'h0, "ovf_after_rst");
        bus_read(4'd2, 32'h0, "ica_after_rst");

        // ---------------- basic counting ----------------
        bus_write(4'd0, 32'h1, "ctrl_start");
        for (int i = 0; i < 10; i++) begin
            dc_en = 1'b1; dc_vbit = 1'b1; dc_hit = i[0];
            @(negedge clk);
        end
        dc_en = 1'b0; dc_vbit = 1'b0; dc_hit = 1'b0;
        // three hits with access, two misses without access, one idle
        for (int i = 0; i < 6; i++) begin
            ic_en   = (i < 3);
            ic_hit  = (i < 3);
            ic_vbit = (i < 5);
            @(negedge clk);
        end
        ic_en = 1'b0; ic_hit = 1'b0; ic_vbit = 1'b0;
        bus_read(4'd0, 32'h1, "ctrl_run");
        bus_read(4'd6, 32'd10, "dca_lo");
        bus_read(4'd7, 32'd0, "dca_hi");
        bus_read(4'd8, 32'd5, "dcm_lo");
        bus_read(4'd2, 32'd3, "ica_lo");
        bus_read(4'd4, 32'd2, "icm_lo");
        bus_read(4'd12, 32'd0, "addr12_zero");
        check("idle_ack", ack, 0);
        check("idle_rdata", rdata, 0);

        // stop: events ignored
        bus_write(4'd0, 32'h2, "ctrl_stop");
        dc_en = 1'b1; dc_vbit = 1'b1;
        repeat (3) @(negedge clk);
        dc_en = 1'b0; dc_vbit = 1'b0;
        bus_read(4'd6, 32'd10, "dca_stopped");
        bus_read(4'd0, 32'h0, "ctrl_stop_rd");
        bus_write(4'd0, 32'h3, "ctrl_start_stop");
        bus_read(4'd0, 32'h1, "ctrl_start_prio");
        bus_write(4'd0, 32'h2, "ctrl_stop2");

        // ---------------- shadow coherence across 32-bit boundary ----------------
        force dut.r_dca = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.r_dca;
        @(negedge clk);
        bus_write(4'd0, 32'h1, "ctrl_start3");
        dc_en = 1'b1;
        bus_read(4'd6, 32'hFFFF_FFFF, "dca_lo_boundary");
        bus_read(4'd7, 32'h0000_0000, "dca_hi_shadow");
        dc_en = 1'b0;
        bus_write(4'd0, 32'h2, "ctrl_stop3");
        bus_read(4'd6, 32'd3, "dca_lo_after");
        bus_read(4'd7, 32'd1, "dca_hi_after");
        bus_write(4'd6, 32'h1234, "wr_counter_ignored");
        bus_read(4'd6, 32'd3, "dca_lo_unwritten");

        // ---------------- ICA wrap and overflow ----------------
        force dut.r_ica = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_ica;
        @(negedge clk);
        bus_write(4'd0, 32'h1, "ctrl_start4");
        ic_en = 1'b1;
        @(negedge clk);
        ic_en = 1'b0;
        check("irq_not_yet", irq, 0);
        @(posedge clk);
        #1;
        check("irq_after_wrap", irq, c_irq_en);
        @(negedge clk);
        bus_read(4'd1, 32'h1, "ovf_ica");
        bus_read(4'd2, 32'h0, "ica_wrapped_lo");
        bus_read(4'd3, 32'h0, "ica_wrapped_hi");
        bus_read(4'd4, 32'd2, "icm_unchanged");

        // ---------------- W1C ----------------
        bus_write(4'd1, 32'hE, "ovf_w1c_other");
        bus_read(4'd1, 32'h1, "ovf_kept");
        bus_write(4'd1, 32'h1, "ovf_w1c");
        bus_read(4'd1, 32'h0, "ovf_cleared");
        check("irq_cleared", irq, 0);

        // set wins over simultaneous W1C
        force dut.r_ica = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_ica;
        @(negedge clk);
        ic_en = 1'b1;
        bus_write(4'd1, 32'h1, "ovf_w1c_collide");
        ic_en = 1'b0;
        bus_read(4'd1, 32'h1, "ovf_set_wins");
        bus_read(4'd2, 32'd1, "ica_after_collide");
        check("irq_set_again", irq, c_irq_en);

        // ---------------- CLEAR during continuous events ----------------
        bus_read(4'd6, 32'd3, "dca_lo_pre_clear");
        ic_en = 1'b1; ic_vbit = 1'b1; dc_en = 1'b1; dc_vbit = 1'b1;
        bus_write(4'd0, 32'h5, "ctrl_clear");
        repeat (3) @(negedge clk);
        ic_en = 1'b0; ic_vbit = 1'b0; dc_en = 1'b0; dc_vbit = 1'b0;
        bus_read(4'd0, 32'h0, "ctrl_after_clear");
        bus_read(4'd7, 32'h0, "shadow_cleared");
        bus_read(4'd2, 32'h0, "ica_cleared");
        bus_read(4'd4, 32'h0, "icm_cleared");
        bus_read(4'd6, 32'h0, "dca_cleared");
        bus_read(4'd8, 32'h0, "dcm_cleared");
        bus_read(4'd1, 32'h0, "ovf_cleared_by_clear");
        check("irq_after_clear", irq, 0);

        // ---------------- reset mid-request ----------------
        bus_write(4'd0, 32'h1, "ctrl_start5");
        ic_en = 1'b1;
        @(negedge clk);
        ic_en = 1'b0;
        req = 1'b1; we = 1'b0; addr = 4'd0;
        #2;
        rst = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_mid_ack", ack, 0);
            check("rst_mid_rdata", rdata, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_ack", ack, 0);
            check("post_rst_irq", irq, 0);
        end
        @(negedge clk);
        bus_read(4'd0, 32'h0, "ctrl_stop_after_rst");
        bus_read(4'd2, 32'h0, "ica_zero_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/perf_mon_ctrl.md
PERF_MON_CTRL -- requirements
Module: perf_mon_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: ic_en, ic_hit, ic_vbit  input  1 each  L1I access strobe, hit, valid-lookup.
REQ-004 SHALL have ports: dc_en, dc_hit, dc_vbit  input  1 each  L1D access strobe, hit, valid-lookup.
REQ-005 SHALL have ports: req  input  1  register request; we  input  1  write when 1; addr  input  4  register index; wdata  input  32  write data.
REQ-006 SHALL have ports: ack  output  1  one-cycle request completion; rdata  output  32  read data, valid while ack=1.
REQ-007 SHALL have port: irq  output  1  overflow interrupt (see Configuration).

Function
REQ-008 SHALL hold four 64-bit counters: ICA (L1I accesses), ICM (L1I misses), DCA (L1D accesses), DCM (L1D misses).
REQ-009 SHALL define the events per cycle: access = x_en; miss = x_vbit AND NOT x_hit; each counter +1 per event cycle, max +1 per cycle.
REQ-010 SHALL implement FSM {STOP, RUN, CLEAR}; counters increment only in RUN.
REQ-011 SHALL decode CTRL (addr 0) writes: bit2 clear -> CLEAR; else bit0 start -> RUN; else bit1 stop -> STOP; bit2 has priority over bit0, bit0 over bit1.
REQ-012 SHALL, in CLEAR, zero all counters, overflow flags and the shadow register for exactly one cycle, then go to STOP; events that cycle are dropped.
REQ-013 SHALL return on CTRL read: bit0 = (state==RUN), bit1 = (state==CLEAR), others 0.
REQ-014 SHALL map OVF (addr 1): bits[3:0] sticky overflow flags {DCM, DCA, ICM, ICA}; write-1-to-clear; reads return flags, upper bits 0.
REQ-015 SHALL map counters read-only: addr 2/3 ICA lo/hi, 4/5 ICM, 6/7 DCA, 8/9 DCM; writes to addr 2..15 ignored; reads of addr 10..15 return 0.
REQ-016 SHALL, on a lo-word read, capture that counter's upper 32 bits into a single 32-bit shadow register in the same cycle as the lo-word sample; hi-word reads return the shadow, not the live value.
REQ-017 SHALL accept a request in any cycle with req=1 and ack=0; assert ack exactly one cycle later for one cycle; rdata sampled at accept; requester holds req/we/addr/wdata until ack; req=1 with ack=1 is not a new request.
REQ-018 SHALL drive rdata to 0 when ack=0.
REQ-019 SHALL wrap a counter from 2^64-1 to 0 and set its overflow flag in the same cycle.
REQ-020 SHALL give set priority over W1C when a flag sets and is cleared in the same cycle.
REQ-021 SHALL apply a CTRL write on the accept edge; state change visible next cycle; an event in the accept cycle counts per the old state.

Reset
REQ-022 SHALL, on rst, asynchronously force: state=STOP, counters=0, flags=0, shadow=0, ack=0, rdata=0, irq=0.
REQ-023 SHALL abandon any in-flight request on rst; no ack issued for it.

Configuration
REQ-024 SHALL honour macro PERF_OVF_IRQ_EN: defined -> irq registered, = OR of overflow flags, 1 cycle after a flag sets, low the cycle after flags clear; undefined -> irq tied 0 and flags still operate.

Verification
REQ-025 SHALL cover: rst, write CTRL=0x1, 10 cycles dc_en=1, dc_vbit=1, dc_hit=0 alternating with dc_hit=1 -> DCA=10, DCM=5, ICA=ICM=0.
REQ-026 SHALL cover: counters running, read addr 6 then addr 7 while DCA increments across the boundary from 0x0000_0000_FFFF_FFFF -> lo=0xFFFF_FFFF, hi=0x0000_0000 (shadow), not 1.
REQ-027 SHALL cover: ICA forced to 2^64-1 (via backdoor), one ic_en pulse in RUN -> ICA=0, OVF=0x1, irq=1 next cycle when PERF_OVF_IRQ_EN defined, irq=0 otherwise.
REQ-028 SHALL cover: write CTRL=0x5 during continuous events -> CLEAR one cycle, then STOP; all counters 0; CTRL reads 0x0.
REQ-029 SHALL cover: W1C OVF=0x1 in the same cycle ICA overflows again -> OVF bit0 remains 1.
REQ-030 SHALL cover: rst asserted mid-request (req=1, ack pending) -> ack never asserts, all outputs 0, state STOP.
